// File: rtl/dsdl2_pkg.sv
// Shared display/entry constants used by group_assembler and group_selector.
package dsdl2_pkg;

    localparam int unsigned GROUP_W    = 4;
    localparam int unsigned NUM_GROUPS = 4;
    localparam int unsigned VALUE_W    = GROUP_W * NUM_GROUPS;
    localparam int unsigned CNT_W      = $clog2(NUM_GROUPS + 1);
    localparam int unsigned SEL_W      = $clog2(NUM_GROUPS);

    localparam logic [GROUP_W-1:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/group_assembler.sv
// group_assembler: builds a 16-bit display value from 4-bit groups, either
// shifted in calculator-style (newest in group 0) or written to an addressed
// group. Supports backspace, clear and an entry count.
// Optional feature: define GROUP_ASSEMBLER_BCD_CHECK_EN to refuse non-BCD
// nibbles (handshake completes, value unchanged) and raise a sticky error.
module group_assembler
    import dsdl2_pkg::*;
#(
    parameter logic [VALUE_W-1:0] RESET_VALUE = 16'h0000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [GROUP_W-1:0] nibble_in,
    input  logic               nibble_valid,
    output logic               nibble_ready,
    input  logic               wr_direct,
    input  logic [SEL_W-1:0]   wr_sel,
    input  logic               backspace,
    input  logic               clear,
    output logic [VALUE_W-1:0] value,
    output logic [CNT_W-1:0]   digit_count,
    output logic               full,
    output logic               error
);

    logic [VALUE_W-1:0] value_q, value_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full_q;
    logic               xfer;
    logic               xfer_write;
    logic [CNT_W-1:0]   sel_cnt;

    // Shift entry is refused when full; direct writes may overwrite a full value.
    assign nibble_ready = ~clear & ~backspace & (wr_direct | ~full_q);
    assign xfer         = nibble_valid & nibble_ready;
    assign sel_cnt      = CNT_W'(wr_sel) + CNT_W'(1);

`ifdef GROUP_ASSEMBLER_BCD_CHECK_EN
    logic bcd_bad;
    logic error_q;

    assign bcd_bad    = nibble_in > BCD_MAX;
    assign xfer_write = xfer & ~bcd_bad;

    // Sticky error: set by an accepted non-BCD nibble, dropped by clear/reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            error_q <= 1'b0;
        end else if (clear) begin
            error_q <= 1'b0;
        end else if (xfer & bcd_bad) begin
            error_q <= 1'b1;
        end
    end

    assign error = error_q;
`else
    assign xfer_write = xfer;
    assign error      = 1'b0;
`endif

    // Next value/count: clear beats backspace beats transfer.
    always_comb begin
        value_d = value_q;
        count_d = count_q;
        if (clear) begin
            value_d = RESET_VALUE;
            count_d = '0;
        end else if (backspace) begin
            if (count_q != '0) begin
                value_d = {GROUP_W'(0), value_q[VALUE_W-1:GROUP_W]};
                count_d = count_q - CNT_W'(1);
            end
        end else if (xfer_write) begin
            if (wr_direct) begin
                value_d[32'(wr_sel)*GROUP_W +: GROUP_W] = nibble_in;
                if (sel_cnt > count_q) begin
                    count_d = sel_cnt;
                end
            end else begin
                value_d = {value_q[VALUE_W-GROUP_W-1:0], nibble_in};
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    // State registers; full tracks the next count so it is never a cycle late.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            value_q <= RESET_VALUE;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(NUM_GROUPS));
        end
    end

    assign value       = value_q;
    assign digit_count = count_q;
    assign full        = full_q;

endmodule
